// File: rtl/notch_mac_sequencer.sv
// Serial five-tap MAC controller for a biquad notch filter: one shared multiplier and accumulator,
// shadow/active coefficient banks, x/y history, and valid/ready sample handshakes.
module notch_mac_sequencer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned FRAC  = 14,
   parameter int unsigned ACC_W = 36
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic                    x_valid,
   output logic                    x_ready,
   output logic signed [WIDTH-1:0] y_out,
   output logic                    y_valid,
   input  logic                    y_ready,
   input  logic                    coef_we,
   input  logic [2:0]              coef_addr,
   input  logic signed [WIDTH-1:0] coef_wdata,
   input  logic                    coef_commit,
   output logic                    commit_pend,
   input  logic                    hist_clear,
   output logic                    busy
);

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   // Bank order: b0, b1, b2, a1, a2
   localparam logic signed [WIDTH-1:0] DefCoef [5] = '{
      WIDTH'(16384), WIDTH'(-26453), WIDTH'(16384), WIDTH'(-26453), WIDTH'(15400)
   };

   state_e state_q, state_d;

   logic signed [WIDTH-1:0]   shadow_q [5];
   logic signed [WIDTH-1:0]   shadow_d [5];
   logic signed [WIDTH-1:0]   active_q [5];
   logic signed [WIDTH-1:0]   x_q, x1_q, x2_q, y1_q, y2_q, y_out_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic [2:0]                tap_q;
   logic                      commit_pend_q;
   logic                      clr_pend_q;

   logic signed [WIDTH-1:0]   coef_sel, data_sel;
   logic signed [2*WIDTH-1:0] product;
   logic signed [ACC_W-1:0]   prod_ext, acc_sum, shifted;
   logic signed [WIDTH-1:0]   y_sat;
   logic                      accept, leave_out, apply_commit, hist_zero;

   assign accept    = (state_q == StIdle) && x_valid;
   assign leave_out = (state_q == StOut) && y_ready;

   // Idle commits apply at once unless a sample is taken that edge; others wait for Idle entry.
   assign apply_commit = ((state_q == StIdle) && coef_commit && !x_valid) ||
                         (leave_out && (commit_pend_q || coef_commit));
   assign hist_zero    = (hist_clear && (state_q != StMac)) || (leave_out && clr_pend_q);

   always_comb begin
      coef_sel = '0;
      data_sel = '0;
      case (tap_q)
         3'd0: begin coef_sel = active_q[0]; data_sel = x_q;  end
         3'd1: begin coef_sel = active_q[1]; data_sel = x1_q; end
         3'd2: begin coef_sel = active_q[2]; data_sel = x2_q; end
         3'd3: begin coef_sel = active_q[3]; data_sel = y1_q; end
         3'd4: begin coef_sel = active_q[4]; data_sel = y2_q; end
         default: ;
      endcase
   end

   assign product  = coef_sel * data_sel;
   assign prod_ext = {{(ACC_W-2*WIDTH){product[2*WIDTH-1]}}, product};
   assign acc_sum  = (tap_q >= 3'd3) ? (acc_q - prod_ext) : (acc_q + prod_ext);
   assign shifted  = acc_sum >>> FRAC;

   always_comb begin
      if (shifted[ACC_W-1:WIDTH-1] == {(ACC_W-WIDTH+1){shifted[ACC_W-1]}}) begin
         y_sat = shifted[WIDTH-1:0];
      end else if (shifted[ACC_W-1]) begin
         y_sat = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         y_sat = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         shadow_d[i] = shadow_q[i];
         if (coef_we && (coef_addr == 3'(i))) shadow_d[i] = coef_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (x_valid) state_d = StMac;
         StMac:   if (tap_q == 3'd4) state_d = StOut;
         StOut:   if (y_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      x_ready     = (state_q == StIdle);
      busy        = (state_q != StIdle);
      y_valid     = (state_q == StOut);
      y_out       = y_out_q;
      commit_pend = commit_pend_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         shadow_q      <= DefCoef;
         active_q      <= DefCoef;
         x_q           <= '0;
         x1_q          <= '0;
         x2_q          <= '0;
         y1_q          <= '0;
         y2_q          <= '0;
         y_out_q       <= '0;
         acc_q         <= '0;
         tap_q         <= '0;
         commit_pend_q <= 1'b0;
         clr_pend_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;

         if (apply_commit) begin
            active_q      <= shadow_d;
            commit_pend_q <= 1'b0;
         end else if (coef_commit) begin
            commit_pend_q <= 1'b1;
         end

         if (accept) begin
            x_q   <= x_in;
            acc_q <= '0;
            tap_q <= '0;
         end else if (state_q == StMac) begin
            acc_q <= acc_sum;
            tap_q <= tap_q + 3'd1;
            if (tap_q == 3'd4) y_out_q <= y_sat;
         end

         if (leave_out) begin
            clr_pend_q <= 1'b0;
         end else if ((state_q == StMac) && hist_clear) begin
            clr_pend_q <= 1'b1;
         end

         if (hist_zero) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
         end else if (leave_out) begin
            x2_q <= x1_q;
            x1_q <= x_q;
            y2_q <= y1_q;
            y1_q <= y_out_q;
         end
      end
   end

endmodule

// File: tb/tb_notch_mac_sequencer.sv
// Directed bench for notch_mac_sequencer: pass-through, saturation, backpressure, commit timing,
// history clear, recursion and mid-sample reset, with hand-computed expected outputs.
module tb_notch_mac_sequencer;

   logic               clk;
   logic               reset;
   logic signed [15:0] x_in;
   logic               x_valid;
   logic               x_ready;
   logic signed [15:0] y_out;
   logic               y_valid;
   logic               y_ready;
   logic               coef_we;
   logic [2:0]         coef_addr;
   logic signed [15:0] coef_wdata;
   logic               coef_commit;
   logic               commit_pend;
   logic               hist_clear;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   notch_mac_sequencer #(
      .WIDTH (16),
      .FRAC  (14),
      .ACC_W (36)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .x_in        (x_in),
      .x_valid     (x_valid),
      .x_ready     (x_ready),
      .y_out       (y_out),
      .y_valid     (y_valid),
      .y_ready     (y_ready),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_wdata  (coef_wdata),
      .coef_commit (coef_commit),
      .commit_pend (commit_pend),
      .hist_clear  (hist_clear),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic write_coef(input int addr, input int val);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = 3'(addr);
      coef_wdata = 16'(val);
      @(negedge clk);
      coef_we    = 1'b0;
   endtask

   task automatic commit_idle(input string tag);
      @(negedge clk);
      coef_commit = 1'b1;
      @(negedge clk);
      coef_commit = 1'b0;
      check({tag, "_pend_idle"}, commit_pend, 0);
   endtask

   task automatic load_bank(input int b0, input int b1, input int b2, input int a1,
                            input int a2, input string tag);
      write_coef(0, b0);
      write_coef(1, b1);
      write_coef(2, b2);
      write_coef(3, a1);
      write_coef(4, a2);
      commit_idle(tag);
   endtask

   task automatic clear_hist();
      @(negedge clk);
      hist_clear = 1'b1;
      @(negedge clk);
      hist_clear = 1'b0;
   endtask

   // Returns at the falling edge just after the acceptance edge.
   task automatic send(input int x, input string tag);
      @(negedge clk);
      check({tag, "_x_ready"}, x_ready, 1);
      x_valid = 1'b1;
      x_in    = 16'(x);
      @(negedge clk);
      x_valid = 1'b0;
      check({tag, "_busy"}, busy, 1);
   endtask

   task automatic wait_y(input int exp_lat, input int exp_y, input string tag);
      int n;
      n = 0;
      while (!y_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_y_out"}, y_out, exp_y);
   endtask

   task automatic take(input string tag);
      @(negedge clk);
      hist_clear = 1'b0;
      check({tag, "_y_valid_drop"}, y_valid, 0);
   endtask

   task automatic run(input int x, input int exp_y, input string tag);
      send(x, tag);
      wait_y(5, exp_y, tag);
      take(tag);
   endtask

   initial begin
      reset       = 1'b1;
      x_in        = '0;
      x_valid     = 1'b0;
      y_ready     = 1'b1;
      coef_we     = 1'b0;
      coef_addr   = '0;
      coef_wdata  = '0;
      coef_commit = 1'b0;
      hist_clear  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_x_ready", x_ready, 1);
      check("rst_y_valid", y_valid, 0);
      check("rst_y_out", y_out, 0);
      check("rst_busy", busy, 0);
      check("rst_commit_pend", commit_pend, 0);

      // Pass-through and saturation
      load_bank(16384, 0, 0, 0, 0, "pass");
      run(1000, 1000, "pass");
      load_bank(32767, 0, 0, 0, 0, "sat");
      run(32767, 32767, "sat_pos");
      run(-32768, -32768, "sat_neg");

      // y = x + x1: backpressure, then clear in OUT, then clear deferred from MAC
      load_bank(16384, 16384, 0, 0, 0, "bp");
      clear_hist();
      y_ready = 1'b0;
      send(100, "bp");
      wait_y(5, 100, "bp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_y_out", y_out, 100);
         check("bp_hold_x_ready", x_ready, 0);
      end
      y_ready = 1'b1;
      take("bp");
      run(7, 107, "bp_hist");
      send(5, "clr_out");
      wait_y(5, 12, "clr_out");
      hist_clear = 1'b1;
      take("clr_out");
      run(3, 3, "clr_out_after");
      send(20, "clr_mac");
      hist_clear = 1'b1;
      @(negedge clk);
      hist_clear = 1'b0;
      wait_y(4, 23, "clr_mac");
      take("clr_mac");
      run(1, 1, "clr_mac_after");

      // Commit during MAC, with a same-cycle coefficient write
      load_bank(16384, 0, 0, 0, 0, "cm");
      send(1000, "cm");
      coef_we     = 1'b1;
      coef_addr   = 3'd0;
      coef_wdata  = 16'sd8192;
      coef_commit = 1'b1;
      @(negedge clk);
      coef_we     = 1'b0;
      coef_commit = 1'b0;
      check("cm_pend_mac", commit_pend, 1);
      wait_y(4, 1000, "cm");
      check("cm_pend_out", commit_pend, 1);
      take("cm");
      check("cm_pend_cleared", commit_pend, 0);
      run(1000, 500, "cm_new_bank");

      // Commit together with acceptance in IDLE: sample keeps the old bank
      write_coef(0, 16384);
      @(negedge clk);
      x_valid     = 1'b1;
      x_in        = 16'sd1000;
      coef_commit = 1'b1;
      @(negedge clk);
      x_valid     = 1'b0;
      coef_commit = 1'b0;
      check("cx_pend", commit_pend, 1);
      wait_y(5, 500, "cx");
      take("cx");
      check("cx_pend_cleared", commit_pend, 0);
      run(1000, 1000, "cx_new_bank");

      // Recursion through y1
      load_bank(16384, 0, 0, -8192, 0, "rec");
      clear_hist();
      run(1000, 1000, "rec0");
      run(0, 500, "rec1");
      run(0, 250, "rec2");

      // Reset at tap 2 with a pending commit of an uncommitted shadow value
      write_coef(0, 100);
      send(1000, "rst_mid");
      coef_commit = 1'b1;
      @(negedge clk);
      coef_commit = 1'b0;
      check("rst_mid_pend", commit_pend, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_x_ready", x_ready, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_pend_drop", commit_pend, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rst_mid_no_y_valid", y_valid, 0);
      end
      commit_idle("dflt");
      run(1000, 1000, "dflt0");
      run(0, 0, "dflt1");
      run(0, 60, "dflt2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
